vga3_output: RTL and testbench

VGA3_OUTPUT -- requirements
Module: vga3_output

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing.sv | 92 +++++++++
 rtl/vga3_output.sv | 130 +++++++++++++
 tb/tb_vga3_output.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default VGA timing constants and shared helpers for the vga3_output slice.
package vga_pkg;

  localparam int unsigned VGA_CLK_DIV   = 5;
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam bit          VGA_HS_POL    = 1'b0;
  localparam bit          VGA_VS_POL    = 1'b0;
  localparam int unsigned VGA_COLOR_W   = 8;

  typedef logic [3*VGA_COLOR_W-1:0] rgb_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, horizontal/vertical counters and registered sync outputs.
module vga_timing import vga_pkg::*; #(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter bit          HS_POL    = VGA_HS_POL,
  parameter bit          VS_POL    = VGA_VS_POL
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [3:0]  c_count_o,
  output logic [10:0] h_count_o,
  output logic [10:0] v_count_o,
  output logic        tick_o,
  output logic        visible_o,
  output logic        hs_o,
  output logic        vs_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  C_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] H_RST  = 11'(H_VISIBLE - 8);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [3:0]  c_q, c_d;
  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        tick;

  assign tick = (c_q == C_LAST);

  always_comb begin
    c_d  = tick ? '0 : c_q + 4'd1;
    h_d  = h_q;
    v_d  = v_q;
    hs_d = hs_q;
    vs_d = vs_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
      // Syncs are decoded from the pre-advance counts, so they lag by one pixel.
      hs_d = in_window(h_q, H_SS, H_SE) ? HS_POL : !HS_POL;
      vs_d = in_window(v_q, V_SS, V_SE) ? VS_POL : !VS_POL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q  <= '0;
      h_q  <= H_RST;
      v_q  <= V_LAST;
      hs_q <= !HS_POL;
      vs_q <= !VS_POL;
    end else begin
      c_q  <= c_d;
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign c_count_o = c_q;
  assign h_count_o = h_q;
  assign v_count_o = v_q;
  assign tick_o    = tick;
  assign visible_o = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_o      = hs_q;
  assign vs_o      = vs_q;

endmodule

// File: rtl/vga3_output.sv
// VGA scan-out: line RAM addressing, colour register, frame-latched modes and line/frame pulses.
module vga3_output import vga_pkg::*; #(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter bit          HS_POL    = VGA_HS_POL,
  parameter bit          VS_POL    = VGA_VS_POL,
  parameter int unsigned COLOR_W   = VGA_COLOR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_double,
  input  logic                 cfg_blank,
  input  logic [3*COLOR_W-1:0] cfg_border,
  output logic                 lineram_read,
  output logic [9:0]           lineram_addr,
  input  logic [3*COLOR_W-1:0] lineram_rdata,
  output logic                 start_of_line,
  output logic                 start_of_frame,
  output logic [9:0]           scanline_y,
  output logic [15:0]          frame_count,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B
);

  localparam logic [3:0]  C_HALF = 4'(CLK_DIV / 2);
  localparam logic [3:0]  C_READ = 4'(CLK_DIV - 3);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);

  logic [3:0]  c_count;
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        tick;
  logic        visible;

  vga_timing #(
    .CLK_DIV   (CLK_DIV),
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .HS_POL    (HS_POL),
    .VS_POL    (VS_POL)
  ) u_timing (
    .clk_i     (clock),
    .rst_i     (reset),
    .c_count_o (c_count),
    .h_count_o (h_count),
    .v_count_o (v_count),
    .tick_o    (tick),
    .visible_o (visible),
    .hs_o      (VGA_HS),
    .vs_o      (VGA_VS)
  );

  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 sol_q, sol_d;
  logic                 sof_q, sof_d;
  logic [15:0]          fc_q, fc_d;
  logic                 dbl_q, dbl_d;
  logic                 blank_q, blank_d;
  logic                 line_start;
  logic                 frame_hit;

  assign line_start = (c_count == '0) && (h_count == '0);
  assign frame_hit  = line_start && (v_count == V_VIS);

  always_comb begin
    rgb_d   = rgb_q;
    fc_d    = fc_q;
    dbl_d   = dbl_q;
    blank_d = blank_q;
    sof_d   = frame_hit;
    sol_d   = line_start && (v_count < V_VIS) && (!dbl_q || !v_count[0]);
    // Mode bits only change on the frame boundary so a frame is never torn.
    if (frame_hit) begin
      dbl_d   = cfg_double;
      blank_d = cfg_blank;
      fc_d    = fc_q + 16'd1;
    end
    if (tick) begin
      if (visible) rgb_d = blank_q ? cfg_border : lineram_rdata;
      else         rgb_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q   <= '0;
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
      fc_q    <= '0;
      dbl_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      sol_q   <= sol_d;
      sof_q   <= sof_d;
      fc_q    <= fc_d;
      dbl_q   <= dbl_d;
      blank_q <= blank_d;
    end
  end

  assign lineram_read   = (c_count == C_READ) && visible;
  assign lineram_addr   = dbl_q ? h_count[10:1] : h_count[9:0];
  assign scanline_y     = dbl_q ? v_count[10:1] : v_count[9:0];
  assign start_of_line  = sol_q;
  assign start_of_frame = sof_q;
  assign frame_count    = fc_q;
  assign VGA_CLK        = (c_count >= C_HALF);
  assign VGA_R          = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign VGA_G          = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B          = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga3_output.sv
// Directed bench: default-timing instance for line behaviour, small-timing instance for frame behaviour.
module tb_vga3_output;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Default-parameter instance
  logic       d_rst, d_read, d_sol, d_sof, d_vclk, d_hs, d_vs;
  logic [9:0] d_addr, d_sy;
  logic [15:0] d_fc;
  rgb_t       d_rdata;
  logic [7:0] d_r, d_g, d_b;

  // Small-timing instance
  logic       s_rst, s_dbl, s_blank, s_read, s_sol, s_sof, s_vclk, s_hs, s_vs;
  logic [9:0] s_addr, s_sy;
  logic [15:0] s_fc;
  rgb_t       s_rdata, s_border;
  logic [7:0] s_r, s_g, s_b;

  vga3_output u_def (
    .clock(clk), .reset(d_rst), .cfg_double(1'b0), .cfg_blank(1'b0), .cfg_border(24'h0),
    .lineram_read(d_read), .lineram_addr(d_addr), .lineram_rdata(d_rdata),
    .start_of_line(d_sol), .start_of_frame(d_sof), .scanline_y(d_sy), .frame_count(d_fc),
    .VGA_CLK(d_vclk), .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b)
  );

  vga3_output #(
    .CLK_DIV(3), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clock(clk), .reset(s_rst), .cfg_double(s_dbl), .cfg_blank(s_blank), .cfg_border(s_border),
    .lineram_read(s_read), .lineram_addr(s_addr), .lineram_rdata(s_rdata),
    .start_of_line(s_sol), .start_of_frame(s_sof), .scanline_y(s_sy), .frame_count(s_fc),
    .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  function automatic rgb_t ram_word(input logic [9:0] a);
    return {a[7:0], ~a[7:0], 8'h5A};
  endfunction

  always @(posedge clk) if (d_read) d_rdata <= ram_word(d_addr);
  always @(posedge clk) if (s_read) s_rdata <= ram_word(s_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return d_sol;
      1:       return s_sol;
      default: return s_sof;
    endcase
  endfunction

  // Counts rising edges until the selected pulse is seen at a falling edge.
  task automatic wait_pulse(input int sel, input string tag, output int unsigned n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pick(sel)) break;
      if (n >= 5000) begin
        check({tag, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_d_addr(input logic [9:0] target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (d_addr == target) return;
    end
    check("d_addr_timeout", 0, 1);
  endtask

  int unsigned n, t0, hs_low, vs_low, reads, sols, j, guard;

  initial begin
    d_rst = 1'b1; s_rst = 1'b1;
    s_dbl = 1'b0; s_blank = 1'b0; s_border = '0;
    repeat (3) @(negedge clk);

    // Reset state, default instance
    check("d_rst_rgb", {d_r, d_g, d_b}, 24'h0);
    check("d_rst_hs", d_hs, 1);
    check("d_rst_vs", d_vs, 1);
    check("d_rst_sol", d_sol, 0);
    check("d_rst_sof", d_sof, 0);
    check("d_rst_fc", d_fc, 0);
    check("d_rst_addr", d_addr, 632);
    check("d_rst_sy", d_sy, 524);
    check("d_rst_read", d_read, 0);
    check("d_rst_vclk", d_vclk, 0);

    d_rst = 1'b0;
    wait_pulse(0, "d_sol0", n);
    check("d_first_sol_latency", n, 841);
    check("d_sy_line0", d_sy, 0);
    t0 = cyc;

    // Line 0 pixel colours
    wait_d_addr(10'd1);
    check("d_rgb_h0", {d_r, d_g, d_b}, 24'h00FF5A);
    wait_d_addr(10'd101);
    check("d_rgb_h100", {d_r, d_g, d_b}, 24'h649B5A);
    wait_d_addr(10'd650);
    check("d_rgb_fporch", {d_r, d_g, d_b}, 24'h0);
    wait_d_addr(10'd700);
    check("d_rgb_sync", {d_r, d_g, d_b}, 24'h0);
    wait_d_addr(10'd790);
    check("d_rgb_bporch", {d_r, d_g, d_b}, 24'h0);
    wait_pulse(0, "d_sol1", n);
    check("d_line_period0", cyc - t0, 4000);
    check("d_sy_line1", d_sy, 1);

    // Line 1: strobe and sync counts
    t0 = cyc; hs_low = 0; reads = 0;
    for (guard = 0; guard < 4100; guard++) begin
      @(negedge clk);
      if (d_sol) break;
      if (!d_hs) hs_low++;
      if (d_read) reads++;
      if (!d_vs) check("d_vs_inactive", d_vs, 1);
    end
    check("d_line_period1", cyc - t0, 4000);
    check("d_hs_low_clocks", hs_low, 480);
    check("d_read_strobes", reads, 640);

    // Asynchronous reset in the middle of line 2
    wait_d_addr(10'd300);
    check("d_rgb_h299", {d_r, d_g, d_b}, 24'h2BD45A);
    d_rst = 1'b1;
    #1;
    check("d_arst_rgb", {d_r, d_g, d_b}, 24'h0);
    check("d_arst_addr", d_addr, 632);
    check("d_arst_sy", d_sy, 524);
    check("d_arst_hs", d_hs, 1);
    check("d_arst_read", d_read, 0);
    @(negedge clk);
    d_rst = 1'b0;
    wait_pulse(0, "d_sol_after_rst", n);
    check("d_sol_latency_after_rst", n, 841);

    // Small instance: reset state
    check("s_rst_sy", s_sy, 11);
    check("s_rst_addr", s_addr, 8);
    check("s_rst_rgb", {s_r, s_g, s_b}, 24'h0);
    check("s_rst_hs", s_hs, 1);
    check("s_rst_vs", s_vs, 1);
    check("s_rst_fc", s_fc, 0);
    s_rst = 1'b0;
    wait_pulse(2, "s_sof1", n);
    check("s_fc_1", s_fc, 1);
    t0 = cyc;

    // Frame 1: normal mode, cfg_double raised after line 0 must not take effect
    sols = 0; vs_low = 0; hs_low = 0;
    for (guard = 0; guard < 2000; guard++) begin
      @(negedge clk);
      if (s_sof) break;
      if (!s_vs) vs_low++;
      if (!s_hs) hs_low++;
      if (s_sol) begin
        check("s_f1_sy", s_sy, sols);
        sols++;
        if (sols == 1) s_dbl = 1'b1;
      end
    end
    check("s_frame_period", cyc - t0, 864);
    check("s_f1_sols", sols, 8);
    check("s_vs_low_clocks", vs_low, 144);
    check("s_hs_low_clocks", hs_low, 12 * 12);
    check("s_fc_2", s_fc, 2);

    // Frame 2: doubled; blank raised now must wait for the next frame
    s_dbl = 1'b0; s_blank = 1'b1; s_border = 24'h123456;
    t0 = cyc; sols = 0; j = 0;
    for (guard = 0; guard < 2000; guard++) begin
      @(negedge clk);
      if (s_sof) break;
      if (s_sol) begin
        check("s_f2_sol_sy", s_sy, sols);
        sols++;
      end
      if (s_read) begin
        check("s_f2_addr", s_addr, (j % 16) / 2);
        check("s_f2_sy", s_sy, (j / 16) / 2);
        if (j % 16 == 0) check("s_f2_rgb_first", {s_r, s_g, s_b}, 24'h0);
        else check("s_f2_rgb", {s_r, s_g, s_b}, ram_word(10'(((j % 16) - 1) / 2)));
        j++;
      end
    end
    check("s_f2_period", cyc - t0, 864);
    check("s_f2_sols", sols, 4);
    check("s_f2_reads", j, 128);
    check("s_fc_3", s_fc, 3);

    // Frame 3: blank with border colour, doubling off again
    sols = 0; j = 0;
    for (guard = 0; guard < 2000; guard++) begin
      @(negedge clk);
      if (s_sof) break;
      if (s_sol) sols++;
      if (s_addr == 10'd20 && !s_vclk) check("s_f3_rgb_blanking", {s_r, s_g, s_b}, 24'h0);
      if (s_read) begin
        check("s_f3_addr", s_addr, j % 16);
        if (j % 16 == 0) check("s_f3_rgb_first", {s_r, s_g, s_b}, 24'h0);
        else check("s_f3_rgb_border", {s_r, s_g, s_b}, 24'h123456);
        j++;
      end
    end
    check("s_f3_sols", sols, 8);
    check("s_f3_reads", j, 128);
    check("s_fc_4", s_fc, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
